// File: rtl/decode_pipe_if.sv
// Decode-stage bus: IF/ID inputs, WB write port and ID/EX outputs.
// master = fetch/writeback side, slave = decode_pipe.
interface decode_pipe_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
);
   logic              if_valid;
   logic [15:0]       if_instr;
   logic [DATA_W-1:0] if_pc_next;
   logic              flush;
   logic              wb_en;
   logic [REG_AW-1:0] wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic              id_stall;
   logic              ex_valid;
   logic [15:0]       ex_instr;
   logic [DATA_W-1:0] ex_pc_next;
   logic [DATA_W-1:0] ex_r1;
   logic [DATA_W-1:0] ex_r2;
   logic [DATA_W-1:0] ex_imm5;
   logic [DATA_W-1:0] ex_imm8;
   logic [DATA_W-1:0] ex_imm11;
   logic [REG_AW-1:0] ex_dst;
   logic              ex_regwrt;
   logic              ex_memrd;
   logic              halted;
   logic              err;

   modport master (
      output if_valid, if_instr, if_pc_next, flush,
      output wb_en, wb_reg, wb_data,
      input  id_stall, ex_valid, ex_instr, ex_pc_next,
      input  ex_r1, ex_r2, ex_imm5, ex_imm8, ex_imm11,
      input  ex_dst, ex_regwrt, ex_memrd, halted, err
   );

   modport slave (
      input  if_valid, if_instr, if_pc_next, flush,
      input  wb_en, wb_reg, wb_data,
      output id_stall, ex_valid, ex_instr, ex_pc_next,
      output ex_r1, ex_r2, ex_imm5, ex_imm8, ex_imm11,
      output ex_dst, ex_regwrt, ex_memrd, halted, err
   );
endinterface

// File: rtl/decode_pipe.sv
// Decode stage: register file with WB bypass, operand/immediate decode,
// load-use hazard detection and the ID/EX pipeline register.
module decode_pipe #(
   parameter int DATA_W   = 16,
   parameter int REG_AW   = 3,
   parameter int LINK_REG = 7
) (
   input logic          clk,
   input logic          rst,
   decode_pipe_if.slave bus
);
   localparam int NREG = 2 ** REG_AW;

   logic [DATA_W-1:0] r_rf [NREG];

   logic              r_ex_valid;
   logic [15:0]       r_ex_instr;
   logic [DATA_W-1:0] r_ex_pc_next;
   logic [DATA_W-1:0] r_ex_r1;
   logic [DATA_W-1:0] r_ex_r2;
   logic [DATA_W-1:0] r_ex_imm5;
   logic [DATA_W-1:0] r_ex_imm8;
   logic [DATA_W-1:0] r_ex_imm11;
   logic [REG_AW-1:0] r_ex_dst;
   logic              r_ex_regwrt;
   logic              r_ex_memrd;
   logic              r_halted;
   logic              r_err;

   logic [4:0]        w_op;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd;
   logic [DATA_W-1:0] w_r1;
   logic [DATA_W-1:0] w_r2;
   logic              w_zext;
   logic [DATA_W-1:0] w_imm5;
   logic [DATA_W-1:0] w_imm8;
   logic [DATA_W-1:0] w_imm11;
   logic              w_regwrt;
   logic              w_memrd;
   logic              w_dst_link;
   logic              w_dst_rd;
   logic              w_dst_rt;
   logic [REG_AW-1:0] w_dst;
   logic              w_reads_rs;
   logic              w_reads_rt;
   logic              w_hazard;

   assign w_op = bus.if_instr[15:11];
   assign w_rs = bus.if_instr[10:8];
   assign w_rt = bus.if_instr[7:5];
   assign w_rd = bus.if_instr[4:2];

   // WB write in the same cycle is visible to the decode read
   assign w_r1 = (bus.wb_en && bus.wb_reg == w_rs) ? bus.wb_data : r_rf[w_rs];
   assign w_r2 = (bus.wb_en && bus.wb_reg == w_rt) ? bus.wb_data : r_rf[w_rt];

   assign w_zext = (w_op[4:1] == 4'b0101);

   assign w_imm5 = w_zext
      ? {{(DATA_W-5){1'b0}}, bus.if_instr[4:0]}
      : {{(DATA_W-5){bus.if_instr[4]}}, bus.if_instr[4:0]};
   assign w_imm8 = w_zext
      ? {{(DATA_W-8){1'b0}}, bus.if_instr[7:0]}
      : {{(DATA_W-8){bus.if_instr[7]}}, bus.if_instr[7:0]};
   assign w_imm11 = {{(DATA_W-11){bus.if_instr[10]}}, bus.if_instr[10:0]};

   assign w_regwrt = !(w_op[4:2] == 3'b011 ||
                       w_op[4:1] == 4'b0001 ||
                       w_op[4:1] == 4'b0000 ||
                       w_op[4:1] == 4'b0010 ||
                       w_op == 5'b10000);
   assign w_memrd = (w_op == 5'b10001);

   assign w_dst_link = (w_op[4:1] == 4'b0011);
   assign w_dst_rd = (w_op == 5'b11001) || (w_op == 5'b11010) ||
                     (w_op == 5'b11011) || (w_op[4:2] == 3'b111);
   assign w_dst_rt = (w_op[4:2] == 3'b010) || (w_op[4:2] == 3'b101) ||
                     (w_op == 5'b10001) || (w_op == 5'b10011);

   always_comb begin
      w_dst = w_rs;
      unique case (1'b1)
         w_dst_link: w_dst = REG_AW'(LINK_REG);
         w_dst_rd:   w_dst = w_rd;
         w_dst_rt:   w_dst = w_rt;
         default:    w_dst = w_rs;
      endcase
   end

   assign w_reads_rs = !(w_op[4:1] == 4'b0000 ||
                         w_op[4:1] == 4'b0001 ||
                         w_op == 5'b00100 ||
                         w_op == 5'b00110 ||
                         w_op == 5'b11000);
   assign w_reads_rt = (w_op == 5'b11010) || (w_op == 5'b11011) ||
                       (w_op[4:2] == 3'b111) || (w_op == 5'b10000) ||
                       (w_op == 5'b10011);

   assign w_hazard = r_ex_valid && r_ex_memrd && bus.if_valid &&
                     ((w_reads_rs && w_rs == r_ex_dst) ||
                      (w_reads_rt && w_rt == r_ex_dst));

   assign bus.id_stall = w_hazard && !bus.flush && !r_halted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (bus.wb_en) begin
         r_rf[bus.wb_reg] <= bus.wb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_valid   <= 1'b0;
         r_ex_instr   <= '0;
         r_ex_pc_next <= '0;
         r_ex_r1      <= '0;
         r_ex_r2      <= '0;
         r_ex_imm5    <= '0;
         r_ex_imm8    <= '0;
         r_ex_imm11   <= '0;
         r_ex_dst     <= '0;
         r_ex_regwrt  <= 1'b0;
         r_ex_memrd   <= 1'b0;
      end else if (bus.flush || r_halted || w_hazard) begin
         r_ex_valid  <= 1'b0;
         r_ex_regwrt <= 1'b0;
         r_ex_memrd  <= 1'b0;
      end else begin
         r_ex_valid   <= bus.if_valid;
         r_ex_instr   <= bus.if_instr;
         r_ex_pc_next <= bus.if_pc_next;
         r_ex_r1      <= w_r1;
         r_ex_r2      <= w_r2;
         r_ex_imm5    <= w_imm5;
         r_ex_imm8    <= w_imm8;
         r_ex_imm11   <= w_imm11;
         r_ex_dst     <= w_dst;
         r_ex_regwrt  <= w_regwrt && bus.if_valid;
         r_ex_memrd   <= w_memrd && bus.if_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_halted <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         if (r_ex_valid && r_ex_instr[15:11] == 5'b00000) r_halted <= 1'b1;
         if (bus.flush && r_halted) r_err <= 1'b1;
      end
   end

   assign bus.ex_valid   = r_ex_valid;
   assign bus.ex_instr   = r_ex_instr;
   assign bus.ex_pc_next = r_ex_pc_next;
   assign bus.ex_r1      = r_ex_r1;
   assign bus.ex_r2      = r_ex_r2;
   assign bus.ex_imm5    = r_ex_imm5;
   assign bus.ex_imm8    = r_ex_imm8;
   assign bus.ex_imm11   = r_ex_imm11;
   assign bus.ex_dst     = r_ex_dst;
   assign bus.ex_regwrt  = r_ex_regwrt;
   assign bus.ex_memrd   = r_ex_memrd;
   assign bus.halted     = r_halted;
   assign bus.err        = r_err;
endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: directed instructions push expected
// ID/EX contents; a negedge monitor pops and compares on each ex_valid.
module tb_decode_pipe;
   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] r1;
      logic [15:0] r2;
      logic [15:0] i5;
      logic [15:0] i8;
      logic [15:0] i11;
      logic [2:0]  dst;
      logic        wrt;
      logic        rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t q[$];
   exp_t m_e;

   always #5 clk = ~clk;

   decode_pipe_if dif ();

   decode_pipe dut (
      .clk(clk),
      .rst(rst),
      .bus(dif.slave)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(
      input logic [15:0] instr, input logic [15:0] pc,
      input logic [15:0] r1, input logic [15:0] r2,
      input logic [15:0] i5, input logic [15:0] i8,
      input logic [15:0] i11, input logic [2:0] dst,
      input logic wrt, input logic rd);
      exp_t e;
      e.instr = instr; e.pc = pc; e.r1 = r1; e.r2 = r2;
      e.i5 = i5; e.i8 = i8; e.i11 = i11;
      e.dst = dst; e.wrt = wrt; e.rd = rd;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && dif.ex_valid === 1'b1) begin
         if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_issue: got instr %h want none",
                     dif.ex_instr);
         end else begin
            m_e = q.pop_front();
            chk("ex_instr", 32'(dif.ex_instr), 32'(m_e.instr));
            chk("ex_pc_next", 32'(dif.ex_pc_next), 32'(m_e.pc));
            chk("ex_r1", 32'(dif.ex_r1), 32'(m_e.r1));
            chk("ex_r2", 32'(dif.ex_r2), 32'(m_e.r2));
            chk("ex_imm5", 32'(dif.ex_imm5), 32'(m_e.i5));
            chk("ex_imm8", 32'(dif.ex_imm8), 32'(m_e.i8));
            chk("ex_imm11", 32'(dif.ex_imm11), 32'(m_e.i11));
            chk("ex_dst", 32'(dif.ex_dst), 32'(m_e.dst));
            chk("ex_regwrt", 32'(dif.ex_regwrt), 32'(m_e.wrt));
            chk("ex_memrd", 32'(dif.ex_memrd), 32'(m_e.rd));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dif.if_valid   = 1'b0;
      dif.if_instr   = '0;
      dif.if_pc_next = '0;
   endtask

   task automatic drive(input logic [15:0] instr, input logic [15:0] pc);
      dif.if_valid   = 1'b1;
      dif.if_instr   = instr;
      dif.if_pc_next = pc;
   endtask

   task automatic issue(input logic [15:0] instr, input logic [15:0] pc,
                        input exp_t e);
      drive(instr, pc);
      q.push_back(e);
      step();
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      dif.flush   = 1'b0;
      dif.wb_en   = 1'b0;
      dif.wb_reg  = '0;
      dif.wb_data = '0;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ex_valid", 32'(dif.ex_valid), 0);
      chk("rst_halted", 32'(dif.halted), 0);
      chk("rst_err", 32'(dif.err), 0);
      chk("rst_id_stall", 32'(dif.id_stall), 0);
      step();

      // r3 gets a value that the later reset must wipe
      dif.wb_en = 1'b1; dif.wb_reg = 3'd3; dif.wb_data = 16'h5555;
      step();

      // bypass: write r2 and decode ADD rs=2 in the same cycle
      dif.wb_reg = 3'd2; dif.wb_data = 16'hBEEF;
      issue(16'hDA04, 16'h0102, mk(16'hDA04, 16'h0102, 16'hBEEF, 16'h0000,
            16'h0004, 16'h0004, 16'h0204, 3'd1, 1'b1, 1'b0));
      dif.wb_reg = 3'd1; dif.wb_data = 16'h1234;
      step();
      dif.wb_en = 1'b0;

      // load-use: LD r1 then ADD rs=1
      issue(16'h8A23, 16'h0104, mk(16'h8A23, 16'h0104, 16'hBEEF, 16'h1234,
            16'h0003, 16'h0023, 16'h0223, 3'd1, 1'b1, 1'b1));
      drive(16'hD918, 16'h0106);
      q.push_back(mk(16'hD918, 16'h0106, 16'h1234, 16'h0000,
                     16'hFFF8, 16'h0018, 16'h0118, 3'd6, 1'b1, 1'b0));
      @(negedge clk);
      chk("lu_stall", 32'(dif.id_stall), 1);
      step();
      @(negedge clk);
      chk("lu_bubble_valid", 32'(dif.ex_valid), 0);
      chk("lu_stall_clear", 32'(dif.id_stall), 0);
      step();
      idle();

      // LD r1 then LBI r1: no source read
      issue(16'h8A23, 16'h0108, mk(16'h8A23, 16'h0108, 16'hBEEF, 16'h1234,
            16'h0003, 16'h0023, 16'h0223, 3'd1, 1'b1, 1'b1));
      drive(16'hC185, 16'h010A);
      q.push_back(mk(16'hC185, 16'h010A, 16'h1234, 16'h0000,
                     16'h0005, 16'hFF85, 16'h0185, 3'd1, 1'b1, 1'b0));
      @(negedge clk);
      chk("lbi_no_stall", 32'(dif.id_stall), 0);
      step();
      idle();

      // LD r1 then J with rs field = 1
      issue(16'h8A23, 16'h010C, mk(16'h8A23, 16'h010C, 16'hBEEF, 16'h1234,
            16'h0003, 16'h0023, 16'h0223, 3'd1, 1'b1, 1'b1));
      drive(16'h2100, 16'h010E);
      q.push_back(mk(16'h2100, 16'h010E, 16'h1234, 16'h0000,
                     16'h0000, 16'h0000, 16'h0100, 3'd1, 1'b0, 1'b0));
      @(negedge clk);
      chk("j_no_stall", 32'(dif.id_stall), 0);
      step();
      idle();

      // hazard and flush together
      issue(16'h8A23, 16'h0110, mk(16'h8A23, 16'h0110, 16'hBEEF, 16'h1234,
            16'h0003, 16'h0023, 16'h0223, 3'd1, 1'b1, 1'b1));
      drive(16'hD918, 16'h0112);
      dif.flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", 32'(dif.id_stall), 0);
      step();
      dif.flush = 1'b0;
      idle();
      @(negedge clk);
      chk("flush_valid", 32'(dif.ex_valid), 0);
      chk("flush_regwrt", 32'(dif.ex_regwrt), 0);
      step();

      // halt
      issue(16'h0000, 16'h0200, mk(16'h0000, 16'h0200, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0));
      step();
      @(negedge clk);
      chk("halted_set", 32'(dif.halted), 1);
      drive(16'hD918, 16'h0202);
      step();
      @(negedge clk);
      chk("halt_no_issue_1", 32'(dif.ex_valid), 0);
      step();
      @(negedge clk);
      chk("halt_no_issue_2", 32'(dif.ex_valid), 0);
      idle();
      dif.flush = 1'b1;
      step();
      dif.flush = 1'b0;
      chk("err_set", 32'(dif.err), 1);

      rst = 1'b1;
      #1;
      chk("rst2_halted", 32'(dif.halted), 0);
      chk("rst2_err", 32'(dif.err), 0);
      step();
      rst = 1'b0;
      step();

      // reset in the middle of a stall
      issue(16'h8A23, 16'h0300, mk(16'h8A23, 16'h0300, 16'h0000, 16'h0000,
            16'h0003, 16'h0023, 16'h0223, 3'd1, 1'b1, 1'b1));
      drive(16'hD918, 16'h0302);
      @(negedge clk);
      chk("rst_stall_before", 32'(dif.id_stall), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_stall_drop", 32'(dif.id_stall), 0);
      chk("rst_stall_valid", 32'(dif.ex_valid), 0);
      idle();
      step();
      rst = 1'b0;
      step();

      // r3 back to zero after reset
      issue(16'hDB74, 16'h0400, mk(16'hDB74, 16'h0400, 16'h0000, 16'h0000,
            16'hFFF4, 16'h0074, 16'h0374, 3'd5, 1'b1, 1'b0));
      step();
      step();
      chk("queue_drained", 32'(q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Pipelined decode stage for the 16-bit core. It holds the register file and detects load-use hazards. It registers all decoded operands, immediates and destination info into an ID/EX pipeline register with a valid bit. It sits between the fetch stage (IF/ID register) and execute, and supports stall, flush and halt.

## Interface
Parameters:
- DATA_W, 16, datapath and register width.
- REG_AW, 3, register index width; the register file holds 2**REG_AW entries.
- LINK_REG, 7, destination register for JAL/JALR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- if_valid  in  1  the IF/ID register holds a real instruction.
- if_instr  in  16  instruction word.
- if_pc_next  in  DATA_W  PC+2 of that instruction.
- flush  in  1  EX redirect; kill the instruction in ID.
- wb_en  in  1  register file write enable from WB.
- wb_reg  in  REG_AW  write index.
- wb_data  in  DATA_W  write data.
- id_stall  out  1  combinational; fetch must hold PC and IF/ID.
- ex_valid  out  1  the ID/EX register holds a real instruction.
- ex_instr  out  16  registered instruction.
- ex_pc_next  out  DATA_W  registered PC+2.
- ex_r1, ex_r2  out  DATA_W  registered Rs and Rt operands.
- ex_imm5, ex_imm8, ex_imm11  out  DATA_W  registered extended immediates.
- ex_dst  out  REG_AW  registered destination index.
- ex_regwrt  out  1  registered register-write flag; 0 whenever ex_valid=0.
- ex_memrd  out  1  registered load flag (LD, opcode 10001).
- halted  out  1  sticky; a HALT has reached EX.
- err  out  1  sticky protocol error.

## Operation
- Opcode is instr[15:11]. rs is instr[10:8]; rt is instr[7:5].
- Register file:
  - Writes at the clock edge when wb_en=1.
  - Reads are combinational with write bypass: if wb_en=1 and wb_reg equals the read index, the read returns wb_data.
- Extends:
  - Zero-extend imm5 and imm8 for opcodes 0101x; sign-extend otherwise.
  - imm11 is always sign-extended.
- ex_regwrt is 0 for opcodes 011xx, 0001x, 0000x, 0010x and 10000; 1 otherwise.
- ex_dst selection:
  - 0011x: LINK_REG.
  - 11001, 11010, 11011, 111xx: instr[4:2].
  - 010xx, 101xx, 10001, 10011: instr[7:5].
  - All others: instr[10:8].
- reads_rs is 0 for 0000x, 0001x, 00100, 00110 and 11000; 1 otherwise.
- reads_rt is 1 for 11010, 11011, 111xx, 10000 and 10011; 0 otherwise.
- Load-use hazard: asserted when all of the following hold:
  - ex_valid=1, ex_memrd=1 and if_valid=1;
  - (reads_rs and rs==ex_dst) or (reads_rt and rt==ex_dst).
- id_stall = hazard & ~flush & ~halted.
- Pipeline register update each edge, highest priority first:
  1. rst: ex_valid=0 and all ex_* outputs = 0.
  2. flush: ex_valid=0 and ex_regwrt=0; other fields don't-care.
  3. halted=1: ex_valid=0 (no further issue).
  4. hazard: insert a bubble (ex_valid=0, ex_regwrt=0, ex_memrd=0).
  5. Otherwise: ex_valid=if_valid and all fields load from decode. ex_regwrt and ex_memrd are ANDed with if_valid.
- halted: set on the edge after ex_valid=1 with ex_instr[15:11]=00000. It stays set until rst.
- err: set when flush=1 while halted=1. It stays set until rst.

## Timing
- Latency from IF/ID to ID/EX is 1 cycle.
- A load-use stall costs exactly 1 bubble:
  - id_stall is high in the cycle the load sits in EX.
  - The dependent instruction enters EX on the next edge.
- Flush in the same cycle as a hazard: flush wins, id_stall=0, bubble inserted.
- A WB write and a decode read of the same register in the same cycle: the decoded operand equals wb_data.
- Reset mid-stall: id_stall drops immediately (asynchronously), because ex_valid is cleared.
- Register file contents after reset are all 0.

## Test plan
- Reset: assert rst mid-run -> ex_valid=0, halted=0, err=0, id_stall=0; reading r3 returns 0x0000.
- Bypass: write wb_reg=2, wb_data=0xBEEF and decode ADD with rs=2 in the same cycle -> ex_r1=0xBEEF one edge later.
- Load-use: LD r1 followed by ADD using rs=1 -> id_stall=1 for one cycle, one ex_valid=0 bubble, then ADD issues with ex_dst=instr[4:2].
- No false stall: LD r1 followed by LBI r1 -> id_stall=0. LD r1 followed by J -> id_stall=0.
- Flush priority: hazard and flush in the same cycle -> id_stall=0 and ex_valid=0 next edge; ex_regwrt=0.
- Halt: HALT reaches EX -> halted=1 next edge; ex_valid then stays 0 despite if_valid=1. Flush afterwards -> err=1.
